// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit {opcode, payload} command frames and serialises RAM readback on MISO.
// Optional macro FRAME_PARITY_EN appends an odd-parity bit to every frame and adds the parity_err output.
module spi_slave_if #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid
`ifdef FRAME_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int W = DATA_WIDTH + 2;
`ifdef FRAME_PARITY_EN
  localparam int FB = W + 1;
`else
  localparam int FB = W;
`endif
  localparam int CW = $clog2(FB + 1);
  localparam int TW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] WORD_END  = CW'(W);
  localparam logic [CW-1:0] FRAME_END = CW'(FB);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    shreg;
  logic            rd_addr_done;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [TW-1:0]   tx_left;
  logic            tx_busy, tx_done;

  logic            active, cnt_en, shift_en, frame_end, frame_ok, tx_load;
  logic [W-1:0]    word, word_fin;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!SS_n) state_nxt = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)              state_nxt = IDLE;
        else if (!MOSI)        state_nxt = WRITE;
        else if (rd_addr_done) state_nxt = READ_DATA;
        else                   state_nxt = READ_ADD;
      end
      default: if (SS_n) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    active   = !SS_n && (state != IDLE);
    cnt_en   = active && (cnt < FRAME_END);
    shift_en = active && (cnt < WORD_END);
    word     = {shreg[W-2:0], MOSI};
`ifdef FRAME_PARITY_EN
    // Word is already complete in shreg; this edge samples the parity bit.
    frame_end = active && (cnt == WORD_END);
    frame_ok  = ^{shreg, MOSI};
    word_fin  = shreg;
`else
    frame_end = shift_en && (cnt == WORD_END - CW'(1));
    frame_ok  = 1'b1;
    word_fin  = word;
`endif
    tx_load = active && (state == READ_DATA) && (cnt == FRAME_END) &&
              !tx_busy && !tx_done && tx_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_done <= 1'b0;
      MISO         <= 1'b0;
      tx_sh        <= '0;
      tx_left      <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
`ifdef FRAME_PARITY_EN
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_valid <= frame_end && frame_ok;
`ifdef FRAME_PARITY_EN
      parity_err <= frame_end && !frame_ok;
`endif
      if (shift_en) shreg <= word;
      if (frame_end && frame_ok) begin
        rx_data <= word_fin;
        if (state == READ_ADD)  rd_addr_done <= 1'b1;
        if (state == READ_DATA) rd_addr_done <= 1'b0;
      end
      if (SS_n || state == IDLE) cnt <= '0;
      else if (cnt_en)           cnt <= cnt + CW'(1);

      if (SS_n) begin
        MISO    <= 1'b0;
        tx_busy <= 1'b0;
        tx_done <= 1'b0;
      end else if (frame_end && !frame_ok && state == READ_DATA) begin
        // Rejected read-data frame: never wait for a reply.
        tx_done <= 1'b1;
        MISO    <= 1'b0;
      end else if (tx_load) begin
        MISO    <= tx_data[DATA_WIDTH-1];
        tx_sh   <= {tx_data[DATA_WIDTH-2:0], 1'b0};
        tx_left <= TW'(DATA_WIDTH - 1);
        tx_busy <= 1'b1;
      end else if (tx_busy) begin
        if (tx_left != '0) begin
          MISO    <= tx_sh[DATA_WIDTH-1];
          tx_sh   <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
          tx_left <= tx_left - TW'(1);
        end else begin
          MISO    <= 1'b0;
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end
      end else begin
        MISO <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: table of command frames plus hand sequences for readback, abort, reset, parity.
module tb_spi_slave_if;
  logic       clk = 1'b0;
  logic       rst_n, SS_n, MOSI, MISO, rx_valid, tx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data;
`ifdef FRAME_PARITY_EN
  logic       parity_err;
`endif

  spi_slave_if #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
`ifdef FRAME_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  int nv, mh, pe;
  logic [9:0] cap;

  typedef struct {
    logic [9:0] w;
    logic [9:0] exp;
    logic       rd;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample just after the rising edge.
  task automatic step(input logic ss, input logic m);
    @(negedge clk);
    SS_n = ss;
    MOSI = m;
    @(posedge clk);
    #1;
    if (rx_valid) begin nv++; cap = rx_data; end
    if (MISO) mh++;
`ifdef FRAME_PARITY_EN
    if (parity_err) pe++;
`endif
  endtask

  task automatic mon_clr();
    nv = 0; mh = 0; pe = 0; cap = '0;
  endtask

  // Start edge, nbits MSB-first, parity bit on full frames, hold edges, then one SS_n-high edge.
  task automatic frame(input logic [9:0] w, input int nbits, input int hold);
    mon_clr();
    step(1'b0, 1'b0);
    for (int i = 9; i >= 10 - nbits; i--) step(1'b0, w[i]);
`ifdef FRAME_PARITY_EN
    if (nbits == 10) step(1'b0, ~^w);
`endif
    for (int h = 0; h < hold; h++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0]  rb;
    logic [9:0]  w;
    tbl[0] = '{w: 10'h012, exp: 10'h012, rd: 1'b0};
    tbl[1] = '{w: 10'h1A5, exp: 10'h1A5, rd: 1'b0};
    tbl[2] = '{w: 10'h212, exp: 10'h212, rd: 1'b1};
    tbl[3] = '{w: 10'h0FF, exp: 10'h0FF, rd: 1'b1};

    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_miso", MISO, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rd_addr_done", dut.rd_addr_done, 0);
    @(negedge clk); rst_n = 1'b1;
    step(1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      frame(tbl[i].w, 10, 1);
      chk($sformatf("tbl%0d_rx_valid_count", i), nv, 1);
      chk($sformatf("tbl%0d_rx_data", i), cap, tbl[i].exp);
      chk($sformatf("tbl%0d_rd_addr_done", i), dut.rd_addr_done, tbl[i].rd);
      chk($sformatf("tbl%0d_miso_quiet", i), mh, 0);
    end

    // Read-data frame with readback 0xA5; a stray tx_valid mid-shift must be ignored.
    w = 10'h300; rb = 8'hA5;
    mon_clr();
    step(1'b0, 1'b0);
    for (int i = 9; i >= 0; i--) step(1'b0, w[i]);
`ifdef FRAME_PARITY_EN
    step(1'b0, ~^w);
`endif
    chk("rdata_rx_valid_count", nv, 1);
    chk("rdata_rx_data", cap, 10'h300);
    chk("rdata_rd_addr_cleared", dut.rd_addr_done, 0);
    step(1'b0, 1'b0);
    chk("rdata_miso_idle_before_tx", MISO, 0);
    tx_valid = 1'b1; tx_data = rb;
    step(1'b0, 1'b0);
    tx_valid = 1'b0; tx_data = 8'h00;
    chk("rdata_miso_b7", MISO, rb[7]);
    for (int j = 6; j >= 0; j--) begin
      if (j == 4) begin tx_valid = 1'b1; tx_data = 8'h00; end
      step(1'b0, 1'b0);
      tx_valid = 1'b0;
      chk($sformatf("rdata_miso_b%0d", j), MISO, rb[j]);
    end
    step(1'b0, 1'b0);
    chk("rdata_miso_after", MISO, 0);
    tx_valid = 1'b1; tx_data = 8'hFF;
    step(1'b0, 1'b0);
    tx_valid = 1'b0;
    chk("rdata_miso_no_reload", MISO, 0);
    step(1'b1, 1'b0);
    chk("rdata_miso_ss_high", MISO, 0);

    // Read frame with rd_addr_done=0 goes to READ_ADD; tx_valid held high must not reach MISO.
    tx_valid = 1'b1; tx_data = 8'hFF;
    frame(10'h2C3, 10, 4);
    tx_valid = 1'b0; tx_data = 8'h00;
    chk("radd_rx_data", cap, 10'h2C3);
    chk("radd_miso_quiet", mh, 0);
    chk("radd_rd_addr_done", dut.rd_addr_done, 1);

    // Write frame aborted after 6 bits.
    frame(10'h0AA, 6, 0);
    chk("abort6_no_rx_valid", nv, 0);
    chk("abort6_rd_addr_kept", dut.rd_addr_done, 1);
    frame(10'h055, 10, 1);
    chk("after_abort_rx_valid_count", nv, 1);
    chk("after_abort_rx_data", cap, 10'h055);

    // SS_n rises on the edge that would sample bit 0.
    frame(10'h1C7, 9, 0);
    chk("abort_bit0_no_rx_valid", nv, 0);

    // Reset after 5 bits of a frame.
    mon_clr();
    step(1'b0, 1'b0);
    for (int i = 9; i >= 5; i--) step(1'b0, tbl[1].w[i]);
    @(negedge clk); rst_n = 1'b0; SS_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_miso", MISO, 0);
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_rx_data", rx_data, 0);
    chk("midrst_rd_addr_done", dut.rd_addr_done, 0);
    @(negedge clk); rst_n = 1'b1;
    frame(10'h012, 10, 1);
    chk("post_rst_rx_valid_count", nv, 1);
    chk("post_rst_rx_data", cap, 10'h012);

`ifdef FRAME_PARITY_EN
    w = 10'h012;
    mon_clr();
    step(1'b0, 1'b0);
    for (int i = 9; i >= 0; i--) step(1'b0, w[i]);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("par_ok_rx_valid_count", nv, 1);
    chk("par_ok_rx_data", cap, 10'h012);
    chk("par_ok_no_err", pe, 0);
    mon_clr();
    step(1'b0, 1'b0);
    for (int i = 9; i >= 0; i--) step(1'b0, w[i]);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("par_bad_no_rx_valid", nv, 0);
    chk("par_bad_err_pulse", pe, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
